// File: rtl/jtframe_rom_nslots_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : jtframe_rom_nslots_if                                      |
// | Description : Bus bundle between the read-only client slots, the slot    |
// |               arbiter/cache and the SDRAM controller read port.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Signals                                                                  |
// |   slot_cs    [SLOTS]      per-slot read request / address valid          |
// |   slot_clr                invalidate every slot cache                    |
// |   slot_addr  [SLOTS*AW]   packed slot addresses, slot n at [n*AW +: AW]  |
// |   offset     [SLOTS*22]   packed SDRAM base per slot, slot n at [n*22]   |
// |   slot_ok    [SLOTS]      slot data valid for the current address        |
// |   slot_dout  [SLOTS*DW]   packed slot read data                          |
// |   sdram_addr [22]         SDRAM 16-bit word address                      |
// |   sdram_req               SDRAM read request                             |
// |   sdram_ack               controller accepted the request                |
// |   data_rdy                data_read valid for the accepted request       |
// |   data_read  [32]         SDRAM read data                                |
// | Modports                                                                 |
// |   master : environment side (clients and SDRAM controller)               |
// |   slave  : the slot arbiter itself                                       |
// +--------------------------------------------------------------------------+
interface jtframe_rom_nslots_if #(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 16
);
  logic [SLOTS-1:0]    slot_cs;
  logic                slot_clr;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS*22-1:0] offset;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*DW-1:0] slot_dout;
  logic [21:0]         sdram_addr;
  logic                sdram_req;
  logic                sdram_ack;
  logic                data_rdy;
  logic [31:0]         data_read;

  modport master (
    output slot_cs, slot_clr, slot_addr, offset,
    input  slot_ok, slot_dout,
    input  sdram_addr, sdram_req,
    output sdram_ack, data_rdy, data_read
  );

  modport slave (
    input  slot_cs, slot_clr, slot_addr, offset,
    output slot_ok, slot_dout,
    output sdram_addr, sdram_req,
    input  sdram_ack, data_rdy, data_read
  );
endinterface
`default_nettype wire

// File: rtl/jtframe_rom_nslots.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : jtframe_rom_nslots                                         |
// | Description : Shares one SDRAM read port among SLOTS read-only clients.  |
// |               Each slot owns a one-entry 32-bit cache; misses are        |
// |               arbitrated round-robin and fetched one at a time.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk : single clock, rising edge                                        |
// |   rst : asynchronous active-high reset                                   |
// |   bus : jtframe_rom_nslots_if.slave (slot side + SDRAM read port)        |
// | Parameters                                                               |
// |   SLOTS : number of client slots (1..8)                                  |
// |   AW    : slot address width in DW-sized units (1..23)                   |
// |   DW    : slot data width (8, 16 or 32)                                  |
// +--------------------------------------------------------------------------+
module jtframe_rom_nslots #(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 16
) (
  input logic                  clk,
  input logic                  rst,
  jtframe_rom_nslots_if.slave  bus
);

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_WAIT_RDY = 2'd2
  } state_t;

  // Cache state
  logic [SLOTS-1:0] r_valid;
  logic [21:0]      r_tag  [SLOTS];
  logic [31:0]      r_data [SLOTS];

  // Transaction state
  state_t         r_state, w_state_nxt;
  logic [SW-1:0]  r_sel,   w_sel_nxt;
  logic [SW-1:0]  r_ptr,   w_ptr_nxt;   // first slot examined by the next search
  logic [21:0]    r_addr,  w_addr_nxt;
  logic           r_req,   w_req_nxt;
  logic           w_fill;

  // Per-slot combinational view
  logic [21:0]      w_word [SLOTS];
  logic [SLOTS-1:0] w_hit;
  logic [SLOTS-1:0] w_pend;

  generate
    for (genvar n = 0; n < SLOTS; n++) begin : g_slot
      logic [22:0] w_ext;
      logic [21:0] w_scaled;

      assign w_ext = 23'(bus.slot_addr[n*AW +: AW]);

      if (DW == 8) begin : g_dw8
        // Two bytes per SDRAM word: the low address bit picks the byte lane
        logic w_unused_hi;
        assign w_unused_hi = ^r_data[n][31:16];
        assign w_scaled = w_ext[22:1];
        assign bus.slot_dout[n*DW +: DW] = w_ext[0] ? r_data[n][15:8] : r_data[n][7:0];
      end else if (DW == 16) begin : g_dw16
        logic w_unused_hi;
        assign w_unused_hi = ^{r_data[n][31:16], w_ext[22]};
        assign w_scaled = w_ext[21:0];
        assign bus.slot_dout[n*DW +: DW] = r_data[n][15:0];
      end else begin : g_dw32
        // Each 32-bit unit spans two SDRAM words
        logic w_unused_hi;
        assign w_unused_hi = ^w_ext[22:21];
        assign w_scaled = {w_ext[20:0], 1'b0};
        assign bus.slot_dout[n*DW +: DW] = r_data[n][31:0];
      end

      // Sum wraps at 22 bits on purpose
      assign w_word[n] = bus.offset[n*22 +: 22] + w_scaled;
      assign w_hit[n]  = r_valid[n] && (r_tag[n] == w_word[n]);
      assign w_pend[n] = bus.slot_cs[n] && !w_hit[n];
      assign bus.slot_ok[n] = bus.slot_cs[n] && w_hit[n];
    end
  endgenerate

  assign bus.sdram_addr = r_addr;
  assign bus.sdram_req  = r_req;

  // Round-robin search: rotate the pending vector so r_ptr lands on bit 0,
  // take the lowest set bit, then rotate the winner back.
  logic [2*SLOTS-1:0] w_rot;
  logic [SW-1:0]      w_off;
  logic [SW:0]        w_sum;
  logic [SW-1:0]      w_grant;
  logic               w_found;

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    w_rot   = {w_pend, w_pend} >> r_ptr;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_off   = SW'(i);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (SW+1)'(SLOTS)) begin
      w_sum = w_sum - (SW+1)'(SLOTS);
    end
    w_grant = w_sum[SW-1:0];
  end

  // Next-state and output logic
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_addr_nxt  = r_addr;
    w_req_nxt   = r_req;
    w_fill      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_nxt = 1'b0;
        if (w_found) begin
          w_state_nxt = ST_WAIT_ACK;
          w_sel_nxt   = w_grant;
          w_ptr_nxt   = (w_grant == SW'(SLOTS - 1)) ? '0 : w_grant + 1'b1;
          w_addr_nxt  = w_word[w_grant];
          w_req_nxt   = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        // data_rdy alongside ack belongs to nothing yet and is ignored
        if (bus.sdram_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (bus.data_rdy) begin
          w_fill      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_addr  <= w_addr_nxt;
      r_req   <= w_req_nxt;
    end
  end

  // The tag comes from the registered request address, so a slot that moved
  // on mid-transaction still gets the line it asked for and simply misses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int n = 0; n < SLOTS; n++) begin
        r_tag[n]  <= '0;
        r_data[n] <= '0;
      end
    end else begin
      if (w_fill) begin
        r_tag[r_sel]  <= r_addr;
        r_data[r_sel] <= bus.data_read;
      end
      // A clear wins over a fill landing in the same cycle
      if (bus.slot_clr) begin
        r_valid <= '0;
      end else if (w_fill) begin
        r_valid[r_sel] <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/jtframe_rom_nslots.md
JTFRAME_ROM_NSLOTS -- requirements
Module: jtframe_rom_nslots

Interface
REQ-001 SHALL have parameter SLOTS, default 4, number of read-only client slots (legal 1..8).
REQ-002 SHALL have parameter AW, default 22, slot address width in DW-sized units (legal 1..23).
REQ-003 SHALL have parameter DW, default 16, slot data width (legal 8, 16, 32; same for all slots).
REQ-004 SHALL have ports (name  direction  width  meaning):
- clk  input  1  single clock; all logic on its rising edge
- rst  input  1  asynchronous, active-high reset
- slot_cs  input  SLOTS  per-slot read request/address valid
- slot_clr  input  1  invalidate all slot caches
- slot_addr  input  SLOTS*AW  packed slot addresses; slot n at [n*AW +: AW]
- offset  input  SLOTS*22  packed per-slot SDRAM base address; slot n at [n*22 +: 22]
- slot_ok  output  SLOTS  slot data valid for current address
- slot_dout  output  SLOTS*DW  packed slot read data
- sdram_addr  output  22  SDRAM 16-bit-word address
- sdram_req  output  1  SDRAM read request
- sdram_ack  input  1  controller accepted request
- data_rdy  input  1  data_read valid for accepted request
- data_read  input  32  SDRAM read data

Function
REQ-005 SHALL compute per-slot word address W(n): DW=8 -> offset + addr>>1; DW=16 -> offset + addr; DW=32 -> offset + (addr<<1); sum truncated to 22 bits, no overflow flag.
REQ-006 SHALL hold per slot a one-entry cache: valid bit, 22-bit tag, 32-bit data.
REQ-007 SHALL define hit(n) = valid(n) and tag(n) == W(n) for the current cycle's inputs.
REQ-008 SHALL drive slot_ok[n] = slot_cs[n] and hit(n), combinationally from registered cache state; slot_ok[n]=0 whenever slot_cs[n]=0.
REQ-009 SHALL drive slot_dout[n] from cache data: DW=8 -> data[7:0] if addr[0]=0 else data[15:8]; DW=16 -> data[15:0]; DW=32 -> data[31:0]; value undefined-but-stable when slot_ok=0.
REQ-010 SHALL treat slot n as pending when slot_cs[n]=1 and hit(n)=0.
REQ-011 SHALL run a three-state FSM: IDLE, WAIT_ACK, WAIT_RDY.
REQ-012 IDLE: if any slot pending, SHALL grant one, register sel=slot, sdram_addr=W(sel), sdram_req=1, go WAIT_ACK; else stay, sdram_req=0.
REQ-013 Grant SHALL be round-robin: search starts at last granted slot + 1 (mod SLOTS); after reset search starts at slot 0.
REQ-014 WAIT_ACK: SHALL hold sdram_req=1 and sdram_addr stable until sdram_ack=1, then drop sdram_req next edge and go WAIT_RDY.
REQ-015 WAIT_RDY: on data_rdy=1 SHALL write data_read into cache(sel), tag(sel)=registered sdram_addr, valid(sel)=1, go IDLE.
REQ-016 Miss latency: slot_ok rises the cycle after the data_rdy cycle; minimum request-to-ok is 3 cycles with ack and rdy each one cycle after the preceding step.
REQ-017 sdram_ack and data_rdy asserted simultaneously in WAIT_ACK SHALL be treated as ack only; data_rdy SHALL be ignored outside WAIT_RDY.
REQ-018 Slot dropping slot_cs or changing address mid-request SHALL NOT abort the transaction; cache fills with the requested tag, hit re-evaluated against current address.
REQ-019 slot_clr SHALL clear all valid bits the next edge; a fill completing in the same cycle as slot_clr SHALL leave valid(sel)=0; FSM continues uninterrupted.
REQ-020 A hit on any slot SHALL be served while the FSM services another slot.
REQ-021 No slot SHALL wait more than SLOTS transactions for a grant while continuously pending.

Reset
REQ-022 On rst SHALL asynchronously force: FSM=IDLE, sdram_req=0, sdram_addr=0, all valid=0, tags=0, cache data=0, sel=0, round-robin pointer such that slot 0 is searched first; hence slot_ok=0, slot_dout=0.
REQ-023 Reset mid-transaction SHALL abandon it; a data_rdy arriving after reset release while in IDLE SHALL be ignored.

Verification
REQ-024 DW=16, slot0 cs, addr=0x100, offset0=0x10_0000 -> sdram_req with sdram_addr=0x10_0100; ack, rdy with data_read=0x1234_ABCD -> slot_ok[0]=1, slot_dout=0xABCD next cycle; re-read addr 0x100 -> no new request.
REQ-025 DW=8, addr=0x201 then 0x200, data_read=0x0000_5AA5 -> sdram_addr=offset+0x100 once, dout 0x5A then 0xA5 with no second request.
REQ-026 All four slots pending simultaneously after reset -> grants in order 0,1,2,3; slot 1 pending again while 3 served -> next grant 0 only if pending, else 1.
REQ-027 slot_clr asserted in the data_rdy cycle for slot 2 -> slot_ok[2] stays 0, new request for slot 2 issued from IDLE.
REQ-028 rst asserted in WAIT_RDY -> sdram_req=0, slot_ok all 0 immediately; stray data_rdy after release -> no cache write.
REQ-029 ack and data_rdy both high in first WAIT_ACK cycle -> data not captured; capture on the later data_rdy only.
